dm_ctrl: RTL

Data-memory responder for the multi-cycle CPU: accepts one load/store request at a time from the control unit and performs it against an internal word-organised RAM after a programmable number of wait states. It handles byte, halfword and word accesses. It returns sign- or zero-extended load data on `rdata`, which feeds the write-back data-select input of the datapath. Misaligned or out-of-range requests complete with an error flag and no memory side effect.

---
 rtl/dm_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dm_ctrl.sv
// ---------------------------------------------------------------------------
// dm_ctrl -- data-memory responder for the multi-cycle CPU.
//
// Accepts one load/store at a time, waits WAIT_CYCLES wait states, then
// performs the access against an internal word-organised RAM. Supports
// byte, halfword and word accesses, with sign- or zero-extended loads.
// Misaligned or out-of-range requests complete with err=1 and have no
// effect on the memory.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the RAM (valid index 0..DEPTH-1)
//   WAIT_CYCLES  wait states before the access cycle (0 is legal)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   request strobe, sampled only while idle
//   we        in   1 = store, 0 = load
//   addr      in   byte address
//   wdata     in   right-justified store data
//   size      in   00 byte, 01 half, 10 word, 11 illegal
//   sign_ext  in   loads only: 1 = sign-extend, 0 = zero-extend
//   busy      out  high from acceptance through the completion cycle
//   ready     out  one-cycle completion pulse
//   rdata     out  load result (0 for stores and errors), held until next accept
//   err       out  request rejected; valid with ready, held until next accept
// ---------------------------------------------------------------------------
module dm_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           sext_q;
    logic           bad_q;
    logic           busy_q;
    logic           ready_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           bad_d;
    logic [AW-1:0]  widx;
    logic [31:0]    rword;
    logic [7:0]     byte_d;
    logic [15:0]    half_d;
    logic [31:0]    load_d;
    logic [31:0]    merge_d;

    // Legality of the request currently on the inputs.
    always_comb begin
        bad_d = 1'b0;
        case (size)
            2'b00:   bad_d = 1'b0;
            2'b01:   bad_d = addr[0];
            2'b10:   bad_d = (addr[1:0] != 2'b00);
            default: bad_d = 1'b1;
        endcase
        if (addr[31:2] >= 30'(DEPTH_WORDS)) begin
            bad_d = 1'b1;
        end
    end

    assign widx  = addr_q[AW+1:2];
    assign rword = mem[widx];

    // Lane extraction for loads and read-modify-write merge for stores.
    always_comb begin
        byte_d  = rword[{addr_q[1:0], 3'b000} +: 8];
        half_d  = rword[{addr_q[1], 4'b0000} +: 16];
        load_d  = rword;
        merge_d = rword;
        case (size_q)
            2'b00: begin
                load_d = sext_q ? {{24{byte_d[7]}}, byte_d} : {24'h0, byte_d};
                merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_d = sext_q ? {{16{half_d[15]}}, half_d} : {16'h0, half_d};
                merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_d  = rword;
                merge_d = wdata_q;
            end
        endcase
    end

    // RAM is not reset. Reset forces the FSM out of ACCESS asynchronously,
    // so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q && !bad_q) begin
            mem[widx] <= merge_d;
        end
    end

    // Illegal requests also pass through the ACCESS slot (with the write
    // suppressed) so their completion lands one cycle after acceptance
    // regardless of WAIT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr[AW+1:0];
                        wdata_q <= wdata;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        bad_q   <= bad_d;
                        busy_q  <= 1'b1;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        if (bad_d || WAIT_CYCLES == 0) begin
                            state_q <= S_ACCESS;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ACCESS: begin
                    state_q <= S_DONE;
                    ready_q <= 1'b1;
                    err_q   <= bad_q;
                    rdata_q <= (we_q || bad_q) ? 32'h0 : load_d;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
